// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO bank with per-bit direction, synchronised
// inputs, atomic set/clear/toggle and byte-masked writes.
// Optional rising-edge interrupt logic is compiled in when the GPIO_IRQ_EN
// macro is defined; without it offsets 6/7 read 0 and irq is tied low.
module gpio_bank #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel,
    input  logic [2:0]       addr,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wmask,
    input  logic             rstrb,
    output logic [31:0]      rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [2:0] OFS_DATA_OUT = 3'd0;
    localparam logic [2:0] OFS_DIR      = 3'd1;
    localparam logic [2:0] OFS_DATA_IN  = 3'd2;
    localparam logic [2:0] OFS_SET      = 3'd3;
    localparam logic [2:0] OFS_CLR      = 3'd4;
    localparam logic [2:0] OFS_TOGGLE   = 3'd5;
    localparam logic [2:0] OFS_IRQ_EN   = 3'd6;
    localparam logic [2:0] OFS_IRQ_STAT = 3'd7;

    logic [31:0]      byte_mask;
    logic [WIDTH-1:0] wmsk;
    logic [WIDTH-1:0] wbits;
    logic             wr;
    logic             rd;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] irq_en;
    logic [WIDTH-1:0] irq_stat;
    logic [31:0]      rd_word;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

    // Bits above WIDTH are never stored; fold them here so they are consumed.
    logic unused_bits;
    assign unused_bits = ^{wdata, byte_mask};

    // Expand the byte strobes to a per-bit mask; only masked bits take part.
    always_comb begin
        byte_mask = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
    end

    assign wmsk  = byte_mask[WIDTH-1:0];
    assign wbits = wdata[WIDTH-1:0] & wmsk;
    assign wr    = sel & (|wmask);
    assign rd    = sel & rstrb;

    // Pad synchroniser; the last stage is the architectural DATA_IN value.
    always_ff @(posedge clk) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
    end

    assign data_in = sync_q[SYNC_STAGES-1];

    // Output data register: plain masked write plus atomic set/clear/toggle.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
        end else if (wr) begin
            case (addr)
                OFS_DATA_OUT: data_out <= (data_out & ~wmsk) | wbits;
                OFS_SET:      data_out <= data_out | wbits;
                OFS_CLR:      data_out <= data_out & ~wbits;
                OFS_TOGGLE:   data_out <= data_out ^ wbits;
                default:      data_out <= data_out;
            endcase
        end
    end

    // Direction register, masked write only.
    always_ff @(posedge clk) begin
        if (reset)                        dir <= '0;
        else if (wr && addr == OFS_DIR)   dir <= (dir & ~wmsk) | wbits;
    end

    assign gpio_out = data_out;
    assign gpio_oe  = dir;

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] w1c;

    // prev tracks DATA_IN; comparing it with the value about to enter
    // DATA_IN flags the edge on the same clock that DATA_IN updates.
    always_ff @(posedge clk) begin
        if (reset) prev <= '0;
        else       prev <= sync_q[SYNC_STAGES-2];
    end

    assign rise = sync_q[SYNC_STAGES-2] & ~prev;
    assign w1c  = (wr && addr == OFS_IRQ_STAT) ? wbits : '0;

    // Interrupt enable, masked read/write.
    always_ff @(posedge clk) begin
        if (reset)                         irq_en <= '0;
        else if (wr && addr == OFS_IRQ_EN) irq_en <= (irq_en & ~wmsk) | wbits;
    end

    // Status is write-one-to-clear; a coincident new edge wins over the clear.
    always_ff @(posedge clk) begin
        if (reset) irq_stat <= '0;
        else       irq_stat <= (irq_stat & ~w1c) | rise;
    end

    // Registered interrupt line from the current status and enable.
    always_ff @(posedge clk) begin
        if (reset) irq <= 1'b0;
        else       irq <= |(irq_stat & irq_en);
    end
`else
    assign irq_en   = '0;
    assign irq_stat = '0;
    assign irq      = 1'b0;
`endif

    // Read mux; write-only offsets and bits above WIDTH read as 0.
    always_comb begin
        rd_word = '0;
        case (addr)
            OFS_DATA_OUT: rd_word[WIDTH-1:0] = data_out;
            OFS_DIR:      rd_word[WIDTH-1:0] = dir;
            OFS_DATA_IN:  rd_word[WIDTH-1:0] = data_in;
            OFS_IRQ_EN:   rd_word[WIDTH-1:0] = irq_en;
            OFS_IRQ_STAT: rd_word[WIDTH-1:0] = irq_stat;
            default:      rd_word = '0;
        endcase
    end

    // Registered read data, captured from pre-write contents and held.
    always_ff @(posedge clk) begin
        if (reset)   rdata <= '0;
        else if (rd) rdata <= rd_word;
    end

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: directed scenarios plus randomized
// traffic compared against a behavioural register-map model.
module tb_gpio_bank;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        rstrb;
    logic [31:0] rdata;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic [31:0] gpio_oe;
    logic        irq;
    logic [31:0] rdata8;
    logic [7:0]  gpio_out8;
    logic [7:0]  gpio_oe8;
    logic        irq8;

    int checks = 0;
    int errors = 0;

    gpio_bank #(.WIDTH(32), .SYNC_STAGES(S)) dut (
        .clk(clk), .reset(reset), .sel(sel), .addr(addr), .wdata(wdata),
        .wmask(wmask), .rstrb(rstrb), .rdata(rdata), .gpio_in(gpio_in),
        .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    gpio_bank #(.WIDTH(8), .SYNC_STAGES(S)) dut8 (
        .clk(clk), .reset(reset), .sel(sel), .addr(addr), .wdata(wdata),
        .wmask(wmask), .rstrb(rstrb), .rdata(rdata8), .gpio_in(gpio_in[7:0]),
        .gpio_out(gpio_out8), .gpio_oe(gpio_oe8), .irq(irq8)
    );

    always #5 clk = ~clk;

    // Reference model of the 32-bit instance
    logic [31:0] mo, md, me, ms, mrd;
    logic        mirq;
    logic [31:0] hist [S];   // hist[0] newest pad sample, hist[S-1] = DATA_IN

    function automatic logic [31:0] expand(input logic [3:0] m);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = {8{m[k]}};
        return r;
    endfunction

    // Advance one clock: model computes next state from current inputs.
    task automatic cycle();
        logic [31:0] n_o, n_d, n_e, n_s, n_rd, wb, din_new;
        logic        n_irq, w, r;
        n_o = mo; n_d = md; n_e = me; n_s = ms; n_rd = mrd; n_irq = mirq;
        w  = sel && (wmask != 4'h0);
        r  = sel && rstrb;
        wb = wdata & expand(wmask);
        din_new = hist[S-2];
        if (r) begin
            case (addr)
                3'd0: n_rd = mo;
                3'd1: n_rd = md;
                3'd2: n_rd = hist[S-1];
                3'd6: n_rd = me;
                3'd7: n_rd = ms;
                default: n_rd = 32'h0;
            endcase
        end
        if (w) begin
            case (addr)
                3'd0: n_o = (mo & ~expand(wmask)) | wb;
                3'd1: n_d = (md & ~expand(wmask)) | wb;
                3'd3: n_o = mo | wb;
                3'd4: n_o = mo & ~wb;
                3'd5: n_o = mo ^ wb;
                default: ;
            endcase
        end
`ifdef GPIO_IRQ_EN
        n_irq = (ms & me) != 32'h0;
        if (w && addr == 3'd6) n_e = (me & ~expand(wmask)) | wb;
        n_s = ms;
        if (w && addr == 3'd7) n_s = n_s & ~wb;
        n_s = n_s | (din_new & ~hist[S-1]);
`endif
        @(posedge clk);
        if (reset) begin
            mo = 0; md = 0; me = 0; ms = 0; mrd = 0; mirq = 0;
            for (int i = 0; i < S; i++) hist[i] = 0;
        end else begin
            mo = n_o; md = n_d; me = n_e; ms = n_s; mrd = n_rd; mirq = n_irq;
            for (int i = S - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = gpio_in;
        end
        #1;
    endtask

    task automatic idle();
        sel = 0; addr = 0; wdata = 0; wmask = 0; rstrb = 0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] m);
        sel = 1; addr = a; wdata = d; wmask = m; rstrb = 0;
        cycle();
        idle();
    endtask

    task automatic rd(input logic [2:0] a);
        sel = 1; addr = a; wdata = 0; wmask = 0; rstrb = 1;
        cycle();
        idle();
    endtask

    task automatic test_reset();
        reset = 1; idle(); gpio_in = 0;
        cycle(); cycle();
        reset = 0;
        checks++;
        if ({gpio_out, gpio_oe, irq, rdata} !== {32'h0, 32'h0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_state out=%h oe=%h irq=%b rdata=%h want all 0", gpio_out, gpio_oe, irq, rdata);
        end
    endtask

    task automatic test_write_atomic();
        wr(3'd0, 32'hDEADBEEF, 4'hF);
        checks++;
        if (gpio_out !== 32'hDEADBEEF) begin
            errors++; $display("FAIL plain_write got=%h want=%h", gpio_out, 32'hDEADBEEF);
        end
        rd(3'd0);
        checks++;
        if (rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL readback got=%h want=%h", rdata, 32'hDEADBEEF);
        end
        wr(3'd3, 32'h0000FFFF, 4'b0001);
        checks++;
        if (gpio_out !== 32'hDEADBEFF) begin
            errors++; $display("FAIL set_masked got=%h want=%h", gpio_out, 32'hDEADBEFF);
        end
        wr(3'd4, 32'h000000F0, 4'hF);
        checks++;
        if (gpio_out !== 32'hDEADBE0F) begin
            errors++; $display("FAIL clr got=%h want=%h", gpio_out, 32'hDEADBE0F);
        end
        wr(3'd5, 32'hFFFFFFFF, 4'b1000);
        checks++;
        if (gpio_out !== 32'h21ADBE0F) begin
            errors++; $display("FAIL toggle_masked got=%h want=%h", gpio_out, 32'h21ADBE0F);
        end
        rd(3'd3);
        checks++;
        if (rdata !== 32'h0) begin
            errors++; $display("FAIL set_reads_zero got=%h want=0", rdata);
        end
    endtask

    task automatic test_width();
        wr(3'd1, 32'hFFFFFFFF, 4'hF);
        checks++;
        if (gpio_oe8 !== 8'hFF || gpio_oe !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL width_oe got8=%h got32=%h want FF/FFFFFFFF", gpio_oe8, gpio_oe);
        end
        rd(3'd1);
        checks++;
        if (rdata8 !== 32'h000000FF) begin
            errors++; $display("FAIL width_readback got=%h want=%h", rdata8, 32'h000000FF);
        end
    endtask

    task automatic test_sync();
        logic [31:0] want [4];
        want[0] = 32'h0; want[1] = 32'h0; want[2] = 32'hA5; want[3] = 32'hA5;
        gpio_in = 0;
        repeat (4) cycle();
        gpio_in = 32'hA5;
        sel = 1; addr = 3'd2; rstrb = 1; wmask = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (rdata !== want[i] || rdata !== mrd) begin
                errors++; $display("FAIL sync_latency cyc=%0d got=%h want=%h", i, rdata, want[i]);
            end
        end
        idle();
    endtask

`ifdef GPIO_IRQ_EN
    task automatic test_irq();
        logic [31:0] want_irq;
        gpio_in = 0;
        repeat (3) cycle();
        wr(3'd6, 32'h1, 4'hF);
        wr(3'd7, 32'hFFFFFFFF, 4'hF);
        cycle();
        gpio_in = 32'h1;
        want_irq = 32'b100;   // irq low after edge+1, edge+2, high at edge+3
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (irq !== want_irq[i] || irq !== mirq) begin
                errors++; $display("FAIL irq_latency edge+%0d got=%b want=%b", i + 1, irq, want_irq[i]);
            end
        end
        rd(3'd7);
        checks++;
        if (rdata !== 32'h1) begin
            errors++; $display("FAIL irq_status got=%h want=1", rdata);
        end
        wr(3'd7, 32'h1, 4'hF);
        cycle();
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_w1c got=%b want=0", irq);
        end
        gpio_in = 0;
        repeat (3) cycle();
        gpio_in = 32'h1;
        cycle();
        wr(3'd7, 32'h1, 4'hF);   // lands on the edge that flags the new rise
        rd(3'd7);
        checks++;
        if (rdata !== 32'h1 || rdata !== mrd) begin
            errors++; $display("FAIL edge_beats_w1c got=%h want=1", rdata);
        end
    endtask
`else
    task automatic test_irq();
        wr(3'd6, 32'hFFFFFFFF, 4'hF);
        gpio_in = 0; repeat (3) cycle();
        gpio_in = 32'hFFFFFFFF; repeat (4) cycle();
        rd(3'd6);
        checks++;
        if (rdata !== 32'h0) begin
            errors++; $display("FAIL irq_en_absent got=%h want=0", rdata);
        end
        rd(3'd7);
        checks++;
        if (rdata !== 32'h0 || irq !== 1'b0) begin
            errors++; $display("FAIL irq_stat_absent got=%h irq=%b want 0/0", rdata, irq);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 79) == 0);
            sel   = ($urandom_range(0, 3) != 0);
            addr  = 3'($urandom_range(0, 7));
            wdata = $urandom;
            wmask = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            rstrb = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 3) == 0) gpio_in = $urandom;
            cycle();
            checks++;
            if ({gpio_out, gpio_oe, irq, rdata} !== {mo, md, mirq, mrd}) begin
                errors++;
                $display("FAIL random cyc=%0d out=%h/%h oe=%h/%h irq=%b/%b rdata=%h/%h (got/want)",
                         i, gpio_out, mo, gpio_oe, md, irq, mirq, rdata, mrd);
            end
        end
        reset = 0; idle();
    endtask

    task automatic test_reset_mid();
        wr(3'd0, 32'h12345678, 4'hF);
        wr(3'd1, 32'h0F0F0F0F, 4'hF);
        wr(3'd6, 32'hFFFFFFFF, 4'hF);
        gpio_in = 32'hFFFFFFFF;
        repeat (4) cycle();
        rd(3'd0);
        sel = 1; addr = 3'd1; rstrb = 1; reset = 1;   // read pending while reset hits
        cycle();
        reset = 0; idle();
        checks++;
        if ({gpio_out, gpio_oe, irq, rdata} !== {32'h0, 32'h0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_mid out=%h oe=%h irq=%b rdata=%h want all 0", gpio_out, gpio_oe, irq, rdata);
        end
    endtask

    initial begin
        reset = 1; idle(); gpio_in = 0;
        mo = 0; md = 0; me = 0; ms = 0; mrd = 0; mirq = 0;
        for (int i = 0; i < S; i++) hist[i] = 0;
        @(negedge clk);
        test_reset();
        test_write_atomic();
        test_width();
        test_sync();
        test_irq();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

// File: doc/gpio_bank.md
# gpio_bank

Parametrised memory-mapped GPIO peripheral; successor to the single write-only 32-bit GPIO_OUT register in SOC. Adds:
- per-bit direction
- synchronised input sampling
- atomic set/clear/toggle
- byte-masked writes
- optional rising-edge interrupt logic

Sits on the SOC IO bus next to the LED/UART registers. Decodes its own word offsets once SEL is asserted.

## Interface
- WIDTH, 32: number of GPIO lines, 1..32; register bits at or above WIDTH read 0 and ignore writes.
- SYNC_STAGES, 2: flip-flop stages on GPIO_IN, minimum 2.
- CLK  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- SEL  input  1  block selected by SOC IO decode.
- ADDR  input  3  word offset within block.
- WDATA  input  32  write data.
- WMASK  input  4  byte write strobes; any bit set with SEL is a write.
- RSTRB  input  1  read strobe, qualified by SEL.
- RDATA  output  32  registered read data.
- GPIO_IN  input  WIDTH  asynchronous pad inputs.
- GPIO_OUT  output  WIDTH  output data register.
- GPIO_OE  output  WIDTH  direction register; 1 = drive.
- IRQ  output  1  OR of (IRQ_STATUS & IRQ_ENABLE); held 0 without GPIO_IRQ_EN.

## Operation
Register map, by ADDR:
- 0 DATA_OUT: RW; drives GPIO_OUT.
- 1 DIR: RW; drives GPIO_OE.
- 2 DATA_IN: RO; last synchronised GPIO_IN; writes ignored.
- 3 SET: WO; DATA_OUT |= masked WDATA; reads 0.
- 4 CLR: WO; DATA_OUT &= ~masked WDATA; reads 0.
- 5 TOGGLE: WO; DATA_OUT ^= masked WDATA; reads 0.
- 6 IRQ_ENABLE: RW.
- 7 IRQ_STATUS: RW1C; bit set on rising edge of synchronised input.

Write rules:
- Byte mask: byte k of WDATA participates only when WMASK[k]=1. Bytes with a clear mask bit are untouched, for plain writes and for SET/CLR/TOGGLE alike.
- A write and a read with SEL in the same cycle are both honoured. The read returns pre-write contents.

Input path and edge detection:
- Synchroniser: SYNC_STAGES-deep chain per bit, plus one extra "previous" register for edge detection.
- Rising edge is sync=1 and prev=0. It sets the IRQ_STATUS bit regardless of DIR or IRQ_ENABLE.
- Same-cycle edge and W1C on one bit: the set wins, so the bit stays 1.

Reset:
- DATA_OUT, DIR, IRQ_ENABLE, IRQ_STATUS, the synchroniser chain, prev and RDATA all clear to 0.
- GPIO_OUT=0, GPIO_OE=0, IRQ=0 on the cycle after RESET is sampled high.
- Reset mid-sequence discards any pending read data. RDATA=0 on the following cycle.

## Timing
- Write: takes effect at the CLK edge sampling SEL & |WMASK. GPIO_OUT/GPIO_OE change that edge, with 1-cycle latency.
- Read: RDATA is valid the cycle after SEL & RSTRB and holds until the next read or reset.
- Input latency: GPIO_IN change to DATA_IN readable takes SYNC_STAGES cycles. IRQ_STATUS sets at the same edge DATA_IN updates.
- IRQ: registered, asserts 1 cycle after the status bit sets (with enable 1). It deasserts 1 cycle after the W1C clears the last enabled bit, or after the enable is cleared.
- No back-pressure; the block accepts one access per cycle.

## Configuration
- GPIO_IRQ_EN defined: the prev register, IRQ_STATUS, IRQ_ENABLE and the IRQ logic are compiled in.
- GPIO_IRQ_EN undefined: that logic is removed. Offsets 6 and 7 read 0 and ignore writes, and IRQ is tied to 0. The rest of the map is unchanged.

## Test plan
- Reset then write 0xDEADBEEF to offset 0 with WMASK=4'hF. GPIO_OUT=0xDEADBEEF one cycle later; reading offset 0 returns 0xDEADBEEF.
- Starting from DATA_OUT=0xDEADBEEF, write 0x0000FFFF to offset 3 with WMASK=4'b0001, giving 0xDEADBEFF. Then write 0x000000F0 to offset 4, giving 0xDEADBE0F. Then write 0xFFFFFFFF to offset 5 with WMASK=4'b1000, giving 0x21ADBE0F.
- WIDTH=8: write 0xFFFFFFFF to DIR. Readback is 0x000000FF and GPIO_OE=8'hFF.
- Drive GPIO_IN from 0x00 to 0xA5 (SYNC_STAGES=2). DATA_IN reads 0xA5 no earlier than 2 cycles after the change, and never a mixed value after settling.
- With GPIO_IRQ_EN and IRQ_ENABLE=0x1, raise GPIO_IN[0]. IRQ=1 at edge+3, and IRQ_STATUS reads 0x1. Write 0x1 to offset 7, and IRQ=0 the following cycle. A same-cycle new edge plus W1C leaves the bit at 1.
- Assert RESET for 1 cycle with all registers nonzero. At the next cycle GPIO_OUT=0, GPIO_OE=0, IRQ=0 and RDATA=0.
